regbank_write_arbiter: RTL
==========================

// Module: regbank_write_arbiter
// PURPOSE
//  Shares the register bank's single write port (regwrite/rdAddr/writeData) among NUM_REQ
//  writeback sources: ALU result, load return, link (ra) write. Round-robin, one grant/cycle.
//  Registers the winner into a one-entry output stage that drives the bank the next cycle.
//  Drops writes to the hard-wired zero register. Exports a pending-write mask for hazard logic.
// PARAMETERS
//  NUM_REQ   3   number of writeback requesters (2..8)
//  ADDR_W    5   register address width (32 registers)
//  DATA_W    32  register data width
//  ZERO_REG  30  register index whose writes are discarded
//  CNT_W     16  width of the contention counter
// PORTS
//  clock         in   1                clock, all state on posedge
//  reset         in   1                synchronous, active-high
//  freeze        in   1                1: no grants (bank being (re)loaded)
//  req_valid     in   NUM_REQ          per-requester write request
//  req_addr      in   NUM_REQ*ADDR_W   dest register, requester i at slice i
//  req_data      in   NUM_REQ*DATA_W   write data, requester i at slice i
//  req_ready     out  NUM_REQ          one-hot grant; transfer = valid & ready
//  regwrite      out  1                bank write enable
//  rdAddr        out  ADDR_W           bank write address
//  writeData     out  DATA_W           bank write data
//  pending_mask  out  32               bit r = 1: output stage holds a write to r
//  contention    out  CNT_W            cycles with >=2 valid requests, saturating
// BEHAVIOUR
//  - Reset: regwrite=0, rdAddr=0, writeData=0, pending_mask=0, contention=0, rr_ptr=0,
//    req_ready=0. Reset mid-operation discards the staged write (not written to bank).
//  - req_ready is combinational from req_valid, rr_ptr, freeze, reset. With freeze or reset
//    high, req_ready=0. Otherwise exactly one bit is set, at the first valid index searched
//    rr_ptr, rr_ptr+1, ... mod NUM_REQ. It is 0 if no request is valid.
//  - Requesters hold valid/addr/data stable until granted. Valid is never withdrawn unaccepted.
//  - Grant in cycle N: addr/data captured at edge N; in cycle N+1 the bank sees regwrite=1.
//    Latency is exactly 1 cycle. Bank writes on edge N+1. The stage never back-pressures,
//    so back-to-back grants every cycle are sustained.
//  - No grant in cycle N: regwrite=0 in N+1. rdAddr/writeData hold their last values.
//  - ZERO_REG: the request is granted normally and rr_ptr advances, but regwrite=0 in N+1.
//  - rr_ptr update on grant to i: rr_ptr <= (i+1) mod NUM_REQ. Unchanged without a grant.
//  - pending_mask = onehot(rdAddr) when regwrite=1, else 0. Registered with the stage.
//  - contention: +1 on each cycle with popcount(req_valid)>=2, also while frozen.
//    It saturates at 2^CNT_W-1.
//  - Same-address requests in one cycle: both are serialised in round-robin order.
//    Ordering against program order is the requesters' responsibility.
//  - No FSM beyond rr_ptr + stage-valid. Round-robin makes any requester wait <= NUM_REQ-1
//    grants.
// STRUCTURE
//  - Shared package zaf_pkg: REG_ADDR_W=5, REG_DATA_W=32, REG_ZERO=30, REG_RA=31.
//    REG_ZERO/REG_RA are shared with the register bank and decoder.
//  - One sub-module: rr_pick (inputs req vector and ptr; outputs one-hot grant + index).
//    It is combinational and reused by future bus arbiters.
//  - Top: rr_ptr register, output stage, pending decode, saturating counter.
// TESTING
//  1 Reset then idle: regwrite=0, pending_mask=0, contention=0, req_ready=0 for 5 cycles.
//  2 Only req1 valid, addr=5, data=0xDEADBEEF -> ready=3'b010 that cycle.
//    Next cycle regwrite=1, rdAddr=5, writeData=0xDEADBEEF, pending_mask=1<<5.
//  3 All 3 valid and held, rr_ptr=0 -> grant order 0,1,2,0 on consecutive cycles.
//    regwrite=1 every cycle from the second; contention increments by 1 per cycle.
//  4 req0 addr=30 -> ready[0]=1 and rr_ptr becomes 1. Next cycle regwrite=0 and
//    pending_mask=0. Reg 30 reads back 0.
//  5 freeze=1 with req2 valid -> ready=0 and no write. Release freeze -> grant next cycle.
//  6 Grant req0 addr=7, reset in the following cycle -> no bank write to reg 7.
//    rr_ptr=0 and all outputs at reset values.

Source files
------------

// File: rtl/zaf_pkg.sv
// Shared register-file constants used by the register bank, the decoder and
// the writeback arbiter.
//   REG_ADDR_W : register address width (32 registers)
//   REG_DATA_W : register data width
//   REG_ZERO   : hard-wired zero register; writes to it are discarded
//   REG_RA     : link register written by call instructions
package zaf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_ZERO   = 30;
    localparam int REG_RA     = 31;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    // One-hot decode of a register index, used for hazard masks.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
        return NUM_REGS'(1) << r;
    endfunction

endpackage

// File: rtl/regbank_write_arbiter_if.sv
// Writeback request bus shared by all requesters of the register-bank write port.
//   req_valid : per-requester write request
//   req_addr  : destination register, requester i at slice i
//   req_data  : write data, requester i at slice i
//   req_ready : one-hot grant from the arbiter; transfer = valid & ready
// Modports: master = requester side, slave = arbiter side.
interface regbank_write_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) ();

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );

endinterface

// File: rtl/regbank_write_arbiter_rr_pick.sv
// Combinational round-robin picker. Searches req starting at index ptr and
// wrapping modulo N; the first set bit wins.
//   req   : request vector
//   ptr   : index with highest priority this cycle
//   grant : one-hot grant (all zero when no request)
//   idx   : binary index of the granted bit (0 when no request)
//   any   : at least one request present
module rr_pick #(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    // One spare bit so ptr + offset cannot overflow before the wrap.
    logic [PTR_W:0] pos;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + (PTR_W+1)'(k);
            if (pos >= (PTR_W+1)'(N)) begin
                pos = pos - (PTR_W+1)'(N);
            end
            if (!any && req[pos[PTR_W-1:0]]) begin
                any                   = 1'b1;
                grant[pos[PTR_W-1:0]] = 1'b1;
                idx                   = pos[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Shares the register bank's single write port among NUM_REQ writeback
// sources (ALU result, load return, link write). One round-robin grant per
// cycle; the winner is registered into a one-entry stage that drives the bank
// in the following cycle. Writes to ZERO_REG are granted but never reach the
// bank.
//   clock, reset : clock and synchronous active-high reset
//   freeze       : suppresses all grants while the bank is being (re)loaded
//   req          : requester bus (slave side), req_ready is the one-hot grant
//   regwrite     : bank write enable
//   rdAddr       : bank write address
//   writeData    : bank write data
//   pending_mask : one-hot of the register the stage is about to write
//   contention   : saturating count of cycles with two or more requests
module regbank_write_arbiter
    import zaf_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int DATA_W   = REG_DATA_W,
    parameter int ZERO_REG = REG_ZERO,
    parameter int CNT_W    = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  freeze,
    regbank_write_arbiter_if.slave req,
    output logic                  regwrite,
    output logic [ADDR_W-1:0]     rdAddr,
    output logic [DATA_W-1:0]     writeData,
    output logic [31:0]           pending_mask,
    output logic [CNT_W-1:0]      contention
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   next_ptr;
    logic [NUM_REQ-1:0] req_eligible;
    logic [NUM_REQ-1:0] grant;
    logic               grant_any;
    logic               stage_valid;
    logic [31:0]        stage_pending;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_data;
    logic               win_drop;
    logic               win_write;
    logic               multi_req;

    logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
    logic [DATA_W-1:0]  data_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i] = req.req_addr[i*ADDR_W +: ADDR_W];
        assign data_arr[i] = req.req_data[i*DATA_W +: DATA_W];
    end

    // Reset and freeze mask requests before the picker so no grant escapes.
    assign req_eligible = (reset || freeze) ? '0 : req.req_valid;

    rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req   (req_eligible),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    assign req.req_ready = grant;

    assign win_addr  = addr_arr[grant_idx];
    assign win_data  = data_arr[grant_idx];
    assign win_drop  = (win_addr == ADDR_W'(ZERO_REG));
    assign win_write = grant_any && !win_drop;
    assign next_ptr  = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    // Contention counts raw requests, so frozen cycles are included.
    assign multi_req = ($countones(req.req_valid) >= 2);

    always_ff @(posedge clock) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            // NOTE: the data-path registers are reset too because they are
            // directly visible outputs and must read zero after reset.
            rr_ptr        <= '0;
            stage_valid   <= 1'b0;
            stage_pending <= '0;
            rdAddr        <= '0;
            writeData     <= '0;
            contention    <= '0;
        end else begin
            stage_valid   <= win_write;
            stage_pending <= win_write ? (32'(1) << win_addr) : '0;
            if (grant_any) begin
                rdAddr    <= win_addr;
                writeData <= win_data;
                rr_ptr    <= next_ptr;
            end
            if (multi_req && (contention != '1)) begin
                contention <= contention + CNT_W'(1);
            end
        end
    end

    // A staged write that meets reset is cancelled before it reaches the bank.
    assign regwrite     = stage_valid && !reset;
    assign pending_mask = reset ? '0 : stage_pending;

endmodule
